// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
//
// Controls the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline
// registers. Produces the execute-stage forwarding selects. Sequences a purge
// after reset and handles multi-cycle data-memory waits with a timeout.
// Keeps two saturating performance counters.
//
// Ports:
//   clk, clr                 clock, asynchronous active-high reset
//   Rs1D, Rs2D               decode-stage source registers
//   Rs1E, Rs2E, RdE          execute-stage source/destination registers
//   ResultSrcE               execute result select (2'b01 = load)
//   RegWriteE/M/W            register-write enables per stage
//   RdM, RdW                 memory/writeback destination registers
//   PCSrcE                   taken branch/jump resolved in execute
//   MemReqM, MemReadyM       data-memory request / completion in M
//   ErrClr                   clears MemErr
//   StallF/D/E/M             hold PC / D / E / M pipeline registers
//   FlushD/E/W               synchronous clear of D / E / W pipeline registers
//   ForwardAE, ForwardBE     operand select: 00 regfile, 10 from M, 01 from W
//   MemErr                   sticky memory-timeout flag
//   LoadStallCnt, FlushCnt   saturating performance counters
module hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             ErrClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] LoadStallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_MEM_WAIT
  } state_t;

  state_t     state, state_nx;
  logic [3:0] purge_cnt, purge_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       lw_stall, mem_wait;
  logic       run_eval;
  logic       err_set;
  logic       inc_lw, inc_fl;

  // M-stage result is newer than W-stage, so it takes precedence.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lw_stall = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = MemReqM && !MemReadyM;

  always_comb begin
    state_nx  = state;
    purge_nx  = purge_cnt;
    wait_nx   = wait_cnt;
    run_eval  = 1'b0;
    err_set   = 1'b0;
    inc_lw    = 1'b0;
    inc_fl    = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;

    case (state)
      S_INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
        if (purge_cnt == 4'd0)
          state_nx = S_RUN;
        else
          purge_nx = purge_cnt - 4'd1;
      end
      S_RUN: begin
        ForwardAE = fwd_sel(Rs1E);
        ForwardBE = fwd_sel(Rs2E);
        if (mem_wait) begin
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          StallM   = 1'b1;
          FlushW   = 1'b1;
          state_nx = S_MEM_WAIT;
          wait_nx  = 8'd1;
        end else begin
          run_eval = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        ForwardAE = fwd_sel(Rs1E);
        ForwardBE = fwd_sel(Rs2E);
        if (MemReadyM) begin
          run_eval = 1'b1;
          state_nx = S_RUN;
          wait_nx  = 8'd0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          // Abandon the access: flag it and let the pipeline move on.
          err_set  = 1'b1;
          state_nx = S_RUN;
          wait_nx  = 8'd0;
        end else begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          StallM  = 1'b1;
          FlushW  = 1'b1;
          wait_nx = wait_cnt + 8'd1;
        end
      end
      default: state_nx = S_INIT;
    endcase

    // Ordinary branch/load-use handling, shared by RUN and the ready cycle
    // of MEM_WAIT.
    if (run_eval) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        inc_fl = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        inc_lw = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= S_INIT;
      purge_cnt    <= 4'(INIT_CYCLES - 1);
      wait_cnt     <= '0;
      MemErr       <= 1'b0;
      LoadStallCnt <= '0;
      FlushCnt     <= '0;
    end else begin
      state     <= state_nx;
      purge_cnt <= purge_nx;
      wait_cnt  <= wait_nx;
      if (err_set)
        MemErr <= 1'b1;
      else if (ErrClr)
        MemErr <= 1'b0;
      if (inc_lw && (LoadStallCnt != '1))
        LoadStallCnt <= LoadStallCnt + CNT_W'(1);
      if (inc_fl && (FlushCnt != '1))
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule
